// File: rtl/game_round_controller_pkg.sv
// Shared types and widths for the number-guessing round controller.
// Used by the interface, the button edge detector and the top FSM.
package game_pkg;

  localparam int TARGET_W = 4;
  localparam int TIME_W   = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_WIN  = 2'd2,
    ST_LOSE = 2'd3
  } state_t;

endpackage

// File: rtl/game_round_controller_if.sv
// Signal bundle between the round controller and its environment:
// buttons, tick source, random_generator and display/LED drivers.
interface game_round_controller_if;
  import game_pkg::*;

  logic                start_bt;
  logic                guess_bt;
  logic [TARGET_W-1:0] guess;
  logic [TARGET_W-1:0] rand_q;
  logic                sec_tick;

  logic                rng_enable;
  logic                rng_timeout;
  logic [TARGET_W-1:0] target;
  logic [TARGET_W-1:0] attempts;
  logic [TIME_W-1:0]   time_left;
  logic                higher;
  logic                lower;
  logic                win;
  logic                lose;
  logic [1:0]          state;

  modport master (
    output start_bt,
    output guess_bt,
    output guess,
    output rand_q,
    output sec_tick,
    input  rng_enable,
    input  rng_timeout,
    input  target,
    input  attempts,
    input  time_left,
    input  higher,
    input  lower,
    input  win,
    input  lose,
    input  state
  );

  modport slave (
    input  start_bt,
    input  guess_bt,
    input  guess,
    input  rand_q,
    input  sec_tick,
    output rng_enable,
    output rng_timeout,
    output target,
    output attempts,
    output time_left,
    output higher,
    output lower,
    output win,
    output lose,
    output state
  );

endinterface

// File: rtl/game_round_controller_bt_edge_detect.sv
// Press/release detector for an active-low debounced button level.
// History resets to 1 (released) so no spurious edge follows reset.
module bt_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic i_bt,
  output logic o_press,
  output logic o_release
);

  logic r_prev;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_prev <= 1'b1;
    end else begin
      r_prev <= i_bt;
    end
  end

  assign o_press   = r_prev & ~i_bt;
  assign o_release = ~r_prev & i_bt;

endmodule

// File: rtl/game_round_controller.sv
// One round of the guessing game: seed capture, timed guessing, win/lose.
// Define HINT_ENABLE_EN to drive the higher/lower hint outputs.
module game_round_controller
  import game_pkg::*;
#(
  parameter int MAX_ATTEMPTS  = 8,
  parameter int ROUND_SECONDS = 30
) (
  input  logic                    clk,
  input  logic                    reset,
  game_round_controller_if.slave  bus
);

  localparam logic [TARGET_W-1:0] MAX_A =
    TARGET_W'(MAX_ATTEMPTS);
  localparam logic [TIME_W-1:0] ROUND_T =
    TIME_W'(ROUND_SECONDS);

  state_t              r_state;
  logic [TARGET_W-1:0] r_target;
  logic [TARGET_W-1:0] r_attempts;
  logic [TIME_W-1:0]   r_time;
  logic                r_higher;
  logic                r_lower;
  logic                r_win;
  logic                r_lose;
  logic                r_rng_en;
  logic                r_rng_to;

  state_t              w_state_n;
  logic [TARGET_W-1:0] w_target_n;
  logic [TARGET_W-1:0] w_att_n;
  logic [TIME_W-1:0]   w_time_n;
  logic                w_higher_n;
  logic                w_lower_n;
  logic                w_win_n;
  logic                w_lose_n;
  logic                w_rng_n;
  logic                w_won;
  logic                w_lost;

  logic w_start_press;
  logic w_start_rel;
  logic w_guess_press;
  logic w_guess_rel;
  logic w_hint_hi;
  logic w_hint_lo;
  logic w_unused_ev;

  bt_edge_detect u_start_ed (
    .clk       (clk),
    .reset     (reset),
    .i_bt      (bus.start_bt),
    .o_press   (w_start_press),
    .o_release (w_start_rel)
  );

  bt_edge_detect u_guess_ed (
    .clk       (clk),
    .reset     (reset),
    .i_bt      (bus.guess_bt),
    .o_press   (w_guess_press),
    .o_release (w_guess_rel)
  );

  assign w_unused_ev = w_start_press | w_guess_rel;

`ifdef HINT_ENABLE_EN
  assign w_hint_hi = bus.guess < r_target;
  assign w_hint_lo = bus.guess > r_target;
`else
  assign w_hint_hi = 1'b0;
  assign w_hint_lo = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_target   <= '0;
      r_attempts <= '0;
      r_time     <= '0;
      r_higher   <= 1'b0;
      r_lower    <= 1'b0;
      r_win      <= 1'b0;
      r_lose     <= 1'b0;
      r_rng_en   <= 1'b0;
      r_rng_to   <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_target   <= w_target_n;
      r_attempts <= w_att_n;
      r_time     <= w_time_n;
      r_higher   <= w_higher_n;
      r_lower    <= w_lower_n;
      r_win      <= w_win_n;
      r_lose     <= w_lose_n;
      r_rng_en   <= w_rng_n;
      r_rng_to   <= w_rng_n;
    end
  end

  always_comb begin
    w_state_n  = r_state;
    w_target_n = r_target;
    w_att_n    = r_attempts;
    w_time_n   = r_time;
    w_higher_n = r_higher;
    w_lower_n  = r_lower;
    w_win_n    = r_win;
    w_lose_n   = r_lose;
    w_won      = 1'b0;
    w_lost     = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (w_start_rel) begin
          w_target_n = bus.rand_q;
          w_att_n    = '0;
          w_time_n   = ROUND_T;
          w_higher_n = 1'b0;
          w_lower_n  = 1'b0;
          w_win_n    = 1'b0;
          w_lose_n   = 1'b0;
          w_state_n  = ST_PLAY;
        end
      end

      ST_PLAY: begin
        if (w_guess_press) begin
          if (r_attempts != MAX_A) begin
            w_att_n = r_attempts + 1'b1;
          end
          if (bus.guess == r_target) begin
            w_won = 1'b1;
          end else begin
            w_higher_n = w_hint_hi;
            w_lower_n  = w_hint_lo;
            if (r_attempts + 1'b1 == MAX_A) begin
              w_lost = 1'b1;
            end
          end
        end
        // Guess is judged before the tick; a correct final guess still wins.
        if (bus.sec_tick && r_time != '0) begin
          w_time_n = r_time - 1'b1;
          if (r_time == TIME_W'(1)) begin
            w_lost = 1'b1;
          end
        end
        if (w_won) begin
          w_win_n   = 1'b1;
          w_state_n = ST_WIN;
        end else if (w_lost) begin
          w_lose_n  = 1'b1;
          w_state_n = ST_LOSE;
        end
      end

      ST_WIN, ST_LOSE: begin
        if (w_start_rel) begin
          w_win_n    = 1'b0;
          w_lose_n   = 1'b0;
          w_higher_n = 1'b0;
          w_lower_n  = 1'b0;
          w_att_n    = '0;
          w_state_n  = ST_IDLE;
        end
      end
    endcase

    w_rng_n = (w_state_n == ST_IDLE);
  end

  assign bus.rng_enable  = r_rng_en;
  assign bus.rng_timeout = r_rng_to;
  assign bus.target      = r_target;
  assign bus.attempts    = r_attempts;
  assign bus.time_left   = r_time;
  assign bus.higher      = r_higher;
  assign bus.lower       = r_lower;
  assign bus.win         = r_win;
  assign bus.lose        = r_lose;
  assign bus.state       = r_state;

endmodule
